// File: rtl/multicycle_main_fsm.sv
// Control FSM for the multicycle RV32I core. Each instruction is sequenced
// through fetch, decode, execute, memory and writeback, and the FSM drives
// the datapath selects and write enables. Memory uses a request/ready
// handshake with an arbitrary number of wait cycles.
// Debug state codes: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5
// EXECR=6 EXECI=7 EXECU=8 ALUWB=9 BEQ=10 JAL=11 ILLEGAL=12.
module multicycle_main_fsm #(
    parameter bit ENABLE_UTYPE    = 1'b0,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_EXECU    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset returns to FETCH at once, even mid memory wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready only matters in the three request states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI, OP_AUIPC:  state_d = ENABLE_UTYPE ? S_EXECU : S_ILLEGAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            // Only loads and stores reach MEMADR; bit 5 separates them
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_EXECU:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state, plus fetch strobes gated by mem_ready;
    // everything is forced low while rst_n is asserted
    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        imm_src    = 3'b000;

        case (opcode)
            OP_LOAD, OP_ITYPE: imm_src = 3'b000;
            OP_STORE:          imm_src = 3'b001;
            OP_BEQ:            imm_src = 3'b010;
            OP_JAL:            imm_src = 3'b011;
            OP_LUI, OP_AUIPC:  imm_src = 3'b100;
            default:           imm_src = 3'b000;
        endcase

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            // lui adds to zero, auipc to OldPC; bit 5 separates them
            S_EXECU: begin
                alu_src_b = 2'b01;
                alu_src_a = opcode[5] ? 2'b11 : 2'b01;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase

        if (!rst_n) begin
            mem_req    = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_update  = 1'b0;
            branch     = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
            imm_src    = 3'b000;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm. Three instances share all inputs:
// 0 = U-type on / halt, 1 = U-type off / halt, 2 = U-type off / refetch.
// A route-based model predicts every output every cycle; directed literal
// checks pin the model on key cycles.
module tb_multicycle_main_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_EXECU = 8, S_ALUWB = 9, S_BEQ = 10, S_JAL = 11,
                   S_ILLEGAL = 12;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           LU = 7'b0110111, AU = 7'b0010111;

    localparam bit [2:0] UT_V = 3'b001;
    localparam bit [2:0] HL_V = 3'b011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;

    logic       mem_req_w [3];
    logic       adr_src_w [3];
    logic       ir_write_w [3];
    logic       pc_update_w [3];
    logic       branch_w [3];
    logic       mem_write_w [3];
    logic       reg_write_w [3];
    logic [1:0] result_src_w [3];
    logic [1:0] alu_src_a_w [3];
    logic [1:0] alu_src_b_w [3];
    logic [1:0] alu_op_w [3];
    logic [2:0] imm_src_w [3];
    logic       illegal_op_w [3];
    logic [3:0] state_w [3];
    logic [22:0] obs [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_main_fsm #(
            .ENABLE_UTYPE   (UT_V[g]),
            .HALT_ON_ILLEGAL(HL_V[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .opcode     (opcode),
            .mem_ready  (mem_ready),
            .mem_req    (mem_req_w[g]),
            .adr_src    (adr_src_w[g]),
            .ir_write   (ir_write_w[g]),
            .pc_update  (pc_update_w[g]),
            .branch     (branch_w[g]),
            .mem_write  (mem_write_w[g]),
            .reg_write  (reg_write_w[g]),
            .result_src (result_src_w[g]),
            .alu_src_a  (alu_src_a_w[g]),
            .alu_src_b  (alu_src_b_w[g]),
            .alu_op     (alu_op_w[g]),
            .imm_src    (imm_src_w[g]),
            .illegal_op (illegal_op_w[g]),
            .state      (state_w[g])
        );
        assign obs[g] = {mem_req_w[g], adr_src_w[g], ir_write_w[g], pc_update_w[g],
                         branch_w[g], mem_write_w[g], reg_write_w[g], result_src_w[g],
                         alu_src_a_w[g], alu_src_b_w[g], alu_op_w[g], imm_src_w[g],
                         illegal_op_w[g], state_w[g]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // After DECODE each opcode follows a fixed route of states; k-th entry or -1
    function automatic int route_state(input logic [6:0] opc, input bit ut, input int k);
        int seq [3];
        seq = '{-1, -1, -1};
        case (opc)
            LW:      seq = '{S_MEMADR, S_MEMREAD, S_MEMWB};
            SW:      seq = '{S_MEMADR, S_MEMWRITE, -1};
            RT:      seq = '{S_EXECR, S_ALUWB, -1};
            IT:      seq = '{S_EXECI, S_ALUWB, -1};
            BQ:      seq = '{S_BEQ, -1, -1};
            JL:      seq = '{S_JAL, S_ALUWB, -1};
            LU, AU:  seq = ut ? '{S_EXECU, S_ALUWB, -1} : '{S_ILLEGAL, -1, -1};
            default: seq = '{S_ILLEGAL, -1, -1};
        endcase
        return (k >= 0 && k < 3) ? seq[k] : -1;
    endfunction

    function automatic logic [22:0] exp_out(input int st, input logic [6:0] opc, input logic mr);
        logic mreq, adr, irw, pcu, br, mw, rw, ill;
        logic [1:0] rs, sa, sb, op;
        logic [2:0] imm;
        {mreq, adr, irw, pcu, br, mw, rw, ill} = '0;
        {rs, sa, sb, op} = '0;
        case (opc)
            SW:      imm = 3'b001;
            BQ:      imm = 3'b010;
            JL:      imm = 3'b011;
            LU, AU:  imm = 3'b100;
            default: imm = 3'b000;
        endcase
        case (st)
            S_FETCH:    begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  begin mreq = 1; adr = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
            S_EXECR:    begin sa = 2'b10; op = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            S_EXECU:    begin sb = 2'b01; sa = (opc == LU) ? 2'b11 : 2'b01; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin sa = 2'b10; op = 2'b01; br = 1; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            default:    ill = 1;
        endcase
        return {mreq, adr, irw, pcu, br, mw, rw, rs, sa, sb, op, imm, ill, st[3:0]};
    endfunction

    // phase: 0 fetch, 1 decode, 2 walking the route at index pos
    int phase [3] = '{0, 0, 0};
    int pos [3] = '{0, 0, 0};
    logic [6:0] dec_op [3];

    function automatic int cur_state(input int i);
        if (phase[i] == 0) return S_FETCH;
        if (phase[i] == 1) return S_DECODE;
        return route_state(dec_op[i], UT_V[i], pos[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                phase[i] <= 0;
                pos[i]   <= 0;
            end else if (phase[i] == 0) begin
                if (mem_ready) phase[i] <= 1;
            end else if (phase[i] == 1) begin
                dec_op[i] <= opcode;
                pos[i]    <= 0;
                phase[i]  <= 2;
            end else begin
                int s;
                s = cur_state(i);
                if (((s == S_MEMREAD || s == S_MEMWRITE) && !mem_ready) ||
                    (s == S_ILLEGAL && HL_V[i])) begin
                    // waiting or parked
                end else if (route_state(dec_op[i], UT_V[i], pos[i] + 1) < 0) begin
                    phase[i] <= 0;
                end else begin
                    pos[i] <= pos[i] + 1;
                end
            end
        end
    end

    // Compare every instance on every falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cycle_dut%0d", i), {9'd0, obs[i]},
                  rst_n ? {9'd0, exp_out(cur_state(i), opcode, mem_ready)} : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        int rw_cnt;
        int ill_cnt;
        rst_n = 1'b0;
        opcode = 7'd0;
        mem_ready = 1'b0;
        step();
        step();
        check("rst_outputs", {9'd0, obs[0]}, 32'd0);

        // lw, no wait
        opcode = LW;
        mem_ready = 1'b1;
        rst_n = 1'b1;
        #1 check("first_mem_req", mem_req_w[0], 1);
        check("first_state", state_w[0], S_FETCH);
        step(); check("lw_decode", state_w[0], S_DECODE);
        step(); check("lw_memadr", state_w[0], S_MEMADR);
        step(); check("lw_memread", state_w[0], S_MEMREAD);
        check("lw_memread_rw", reg_write_w[0], 0);
        step(); check("lw_memwb", state_w[0], S_MEMWB);
        check("lw_reg_write", reg_write_w[0], 1);
        check("lw_result_src", result_src_w[0], 2'b01);
        check("lw_imm", imm_src_w[0], 3'b000);
        step(); check("lw_back_fetch", state_w[0], S_FETCH);

        // fetch with two wait cycles, then sw with three wait cycles
        mem_ready = 1'b0;
        opcode = SW;
        #1 check("fw_irw0", ir_write_w[0], 0);
        step(); check("fw_irw1", ir_write_w[0], 0);
        check("fw_pcu1", pc_update_w[0], 0);
        step();
        mem_ready = 1'b1;
        #1 check("fw_irw2", ir_write_w[0], 1);
        check("fw_pcu2", pc_update_w[0], 1);
        step(); check("fw_decode", state_w[0], S_DECODE);
        check("fw_irw_done", ir_write_w[0], 0);
        step();
        mem_ready = 1'b0;
        step(); check("sw_memwrite", state_w[0], S_MEMWRITE);
        cnt = 0;
        rw_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            #1;
            if (mem_write_w[0] && mem_req_w[0]) cnt++;
            if (reg_write_w[0]) rw_cnt++;
            step();
        end
        check("sw_write_cycles", cnt, 4);
        check("sw_no_reg_write", rw_cnt, 0);
        check("sw_back_fetch", state_w[0], S_FETCH);

        // beq then jal
        opcode = BQ;
        step(); step();
        check("beq_state", state_w[0], S_BEQ);
        check("beq_branch", branch_w[0], 1);
        check("beq_alu_op", alu_op_w[0], 2'b01);
        check("beq_imm", imm_src_w[0], 3'b010);
        step(); check("beq_fetch", state_w[0], S_FETCH);
        opcode = JL;
        step(); step();
        check("jal_state", state_w[0], S_JAL);
        check("jal_pc_update", pc_update_w[0], 1);
        step();
        check("jal_aluwb", state_w[0], S_ALUWB);
        check("jal_reg_write", reg_write_w[0], 1);
        check("jal_imm", imm_src_w[0], 3'b011);
        step();

        // R-type and I-type round trips
        opcode = RT;
        step(); step();
        check("rt_alu_op", alu_op_w[0], 2'b10);
        step(); step();
        opcode = IT;
        repeat (4) step();
        check("it_back_fetch", state_w[0], S_FETCH);

        // lui: executes on inst 0, halts inst 1, pulses inst 2
        opcode = LU;
        step(); step();
        check("lui_execu", state_w[0], S_EXECU);
        check("lui_src_a", alu_src_a_w[0], 2'b11);
        check("lui_ill_halt", illegal_op_w[1], 1);
        check("lui_ill_pulse", illegal_op_w[2], 1);
        step();
        check("lui_aluwb", state_w[0], S_ALUWB);
        check("lui_pulse_end", illegal_op_w[2], 0);
        ill_cnt = 0;
        repeat (5) begin
            step();
            if (illegal_op_w[1]) ill_cnt++;
        end
        check("lui_held", ill_cnt, 5);
        check("lui_held_state", state_w[1], S_ILLEGAL);

        // reset resyncs all instances, then abort during a store wait
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        opcode = SW;
        mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step(); step();
        check("abort_pre", mem_write_w[0], 1);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {9'd0, obs[0]}, 32'd0);
        check("abort_mem_req", mem_req_w[1], 0);
        step(); step();
        rst_n = 1'b1;
        #1 check("restart_state", state_w[0], S_FETCH);
        check("restart_mem_req", mem_req_w[0], 1);

        // auipc after restart
        mem_ready = 1'b1;
        opcode = AU;
        step(); step();
        check("auipc_src_a", alu_src_a_w[0], 2'b01);
        check("auipc_imm", imm_src_w[0], 3'b100);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
